// File: rtl/bpss_req_split.sv
// bpss_req_split: splits bypass descriptors into chunks that never cross a
// 2^BOUND_BITS address boundary, one registered chunk per output handshake.
module bpss_req_split #(
   parameter int VADDR_BITS = 48,
   parameter int LEN_BITS   = 28,
   parameter int PID_BITS   = 6,
   parameter int BOUND_BITS = 12
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [VADDR_BITS-1:0] s_vaddr,
   input  logic [LEN_BITS-1:0]   s_len,
   input  logic [PID_BITS-1:0]   s_pid,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [VADDR_BITS-1:0] m_vaddr,
   output logic [LEN_BITS-1:0]   m_len,
   output logic [PID_BITS-1:0]   m_pid,
   output logic                  m_last,
   output logic [31:0]           chunk_cnt,
   output logic                  busy
);
   localparam int CW = LEN_BITS + BOUND_BITS + 1;
   typedef enum logic {IDLE, SPLIT} state_t;
   state_t state, nxt;
   logic [VADDR_BITS-1:0] cur_vaddr, src_vaddr;
   logic [LEN_BITS-1:0]   rem_len, src_len, chunk;
   logic [PID_BITS-1:0]   pid_r;
   logic [CW-1:0]         room;
   logic                  last_r, fin_r, fin, accept, load, hs;

   assign s_ready = state == IDLE && !areset;
   assign busy    = state != IDLE;
   assign hs      = m_valid && m_ready;
   assign accept  = state == IDLE && s_valid;
   assign load    = accept || (hs && !fin_r);

   // cur_vaddr/rem_len always describe the chunk after the one on m_*
   always_comb begin
      src_vaddr = state == IDLE ? s_vaddr : cur_vaddr;
      src_len   = state == IDLE ? s_len : rem_len;
      room      = (CW'(1) << BOUND_BITS) - CW'(src_vaddr[BOUND_BITS-1:0]);
      chunk     = CW'(src_len) < room ? src_len : room[LEN_BITS-1:0];
      fin       = chunk == src_len;
      nxt       = accept ? SPLIT : (hs && fin_r) ? IDLE : state;
   end

   always_ff @(posedge aclk)
      if (areset) state <= IDLE;
      else state <= nxt;

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_valid   <= 1'b0;
         m_vaddr   <= '0;
         m_len     <= '0;
         m_pid     <= '0;
         m_last    <= 1'b0;
         chunk_cnt <= '0;
         cur_vaddr <= '0;
         rem_len   <= '0;
         pid_r     <= '0;
         last_r    <= 1'b0;
         fin_r     <= 1'b0;
      end else begin
         m_valid <= nxt == SPLIT;
         if (hs) chunk_cnt <= chunk_cnt + 32'd1;
         if (accept) begin
            pid_r  <= s_pid;
            last_r <= s_last;
         end
         if (load) begin
            m_vaddr   <= src_vaddr;
            m_len     <= chunk;
            m_pid     <= accept ? s_pid : pid_r;
            m_last    <= fin && (accept ? s_last : last_r);
            fin_r     <= fin;
            cur_vaddr <= src_vaddr + VADDR_BITS'(chunk);
            rem_len   <= src_len - chunk;
         end
      end
   end
endmodule
